stack_spill_fill: RTL

Client-facing stack engine with automatic spill and fill to a backing memory region. It holds the top LIFO_DEPTH entries in an internal circular register stack. When a push arrives on a full stack, it writes the oldest entry to memory. When a pop arrives on an empty stack, it reads the most recently spilled entry back. It is the memory-side counterpart of the core's small hardware LIFO, sitting between a core stack client (return-address or operand stack) and the data memory port.

---
 rtl/stack_spill_fill_pkg.sv | 15 +
 rtl/stack_ring_regs.sv | 31 +++
 rtl/stack_spill_fill.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/stack_spill_fill_pkg.sv
// Shared definitions for the spill/fill stack engine: FSM encoding and
// the entry-size helper used to turn slot numbers into byte addresses.
package stack_spill_fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPILL = 2'd1,
    FILL  = 2'd2
  } state_e;

  function automatic int entry_bytes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/stack_ring_regs.sv
// Circular register array holding the on-chip top of stack: one write
// port and two combinational read ports (top and bottom slot).
module stack_ring_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int LIFO_DEPTH = 4,
  parameter int IDX_W      = $clog2(LIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      top_idx_i,
  input  logic [IDX_W-1:0]      bot_idx_i,
  output logic [DATA_WIDTH-1:0] top_o,
  output logic [DATA_WIDTH-1:0] bot_o
);

  logic [DATA_WIDTH-1:0] slots_q [LIFO_DEPTH];

  // NOTE: storage is deliberately not reset; the counters in the parent
  // decide which slots hold live data, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (we_i) begin
      slots_q[waddr_i] <= wdata_i;
    end
  end

  assign top_o = slots_q[top_idx_i];
  assign bot_o = slots_q[bot_idx_i];

endmodule

// File: rtl/stack_spill_fill.sv
// Stack engine keeping the top LIFO_DEPTH entries on chip, spilling the
// oldest entry to memory on overflow and filling it back on underflow.
module stack_spill_fill
  import stack_spill_fill_pkg::*;
#(
  parameter int                     DATA_WIDTH   = 32,
  parameter int                     LIFO_DEPTH   = 4,
  parameter int                     ADDRESS_BITS = 32,
  parameter logic [ADDRESS_BITS-1:0] BASE_ADDR   = '0,
  parameter int                     MEM_ENTRIES  = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic                    ready_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    valid_o,
  output logic                    empty_o,
  output logic                    overflow_o,
  output logic                    underflow_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDRESS_BITS-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_ack_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int IDX_W = $clog2(LIFO_DEPTH);
  localparam int CNT_W = $clog2(LIFO_DEPTH + 1);
  localparam int MC_W  = $clog2(MEM_ENTRIES + 1);

  localparam logic [ADDRESS_BITS-1:0] ENTRY_BYTES = ADDRESS_BITS'(entry_bytes(DATA_WIDTH));
  localparam logic [CNT_W-1:0]        LOCAL_FULL  = CNT_W'(LIFO_DEPTH);
  localparam logic [MC_W-1:0]         MEM_FULL    = MC_W'(MEM_ENTRIES);

  function automatic logic [ADDRESS_BITS-1:0] slot_addr(input logic [MC_W-1:0] slot);
    return BASE_ADDR + ADDRESS_BITS'(slot) * ENTRY_BYTES;
  endfunction

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        bottom_q, bottom_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [MC_W-1:0]         mem_count_q, mem_count_d;
  logic [DATA_WIDTH-1:0]   push_data_q, push_data_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    overflow_q, overflow_d;
  logic                    underflow_q, underflow_d;
  logic [ADDRESS_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

  logic                  ring_we;
  logic [IDX_W-1:0]      ring_waddr;
  logic [DATA_WIDTH-1:0] ring_wdata;
  logic [IDX_W-1:0]      top_idx, push_idx;
  logic [DATA_WIDTH-1:0] top_data, bot_data;
  logic                  local_nonempty;

  // Index arithmetic wraps naturally; a full count aliases to 0 in IDX_W bits.
  assign push_idx       = bottom_q + count_q[IDX_W-1:0];
  assign top_idx        = push_idx - IDX_W'(1);
  assign local_nonempty = (count_q != '0);

  stack_ring_regs #(
    .DATA_WIDTH (DATA_WIDTH),
    .LIFO_DEPTH (LIFO_DEPTH),
    .IDX_W      (IDX_W)
  ) u_ring (
    .clk       (clk),
    .we_i      (ring_we && !reset),
    .waddr_i   (ring_waddr),
    .wdata_i   (ring_wdata),
    .top_idx_i (top_idx),
    .bot_idx_i (bottom_q),
    .top_o     (top_data),
    .bot_o     (bot_data)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a value unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    bottom_d     = bottom_q;
    count_d      = count_q;
    mem_count_d  = mem_count_q;
    push_data_d  = push_data_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ring_we      = 1'b0;
    ring_waddr   = top_idx;
    ring_wdata   = data_i;

    unique case (state_q)
      IDLE: begin
        if (push_i && pop_i) begin
          valid_d = 1'b1;
          if (local_nonempty) begin
            data_d  = top_data;
            ring_we = 1'b1;
          end else begin
            data_d = data_i;
          end
        end else if (push_i) begin
          if (count_q < LOCAL_FULL) begin
            ring_we    = 1'b1;
            ring_waddr = push_idx;
            count_d    = count_q + CNT_W'(1);
          end else if (mem_count_q < MEM_FULL) begin
            push_data_d = data_i;
            mem_addr_d  = slot_addr(mem_count_q);
            mem_wdata_d = bot_data;
            state_d     = SPILL;
          end else begin
            overflow_d = 1'b1;
          end
        end else if (pop_i) begin
          if (local_nonempty) begin
            data_d  = top_data;
            valid_d = 1'b1;
            count_d = count_q - CNT_W'(1);
          end else if (mem_count_q != '0) begin
            mem_addr_d = slot_addr(mem_count_q - MC_W'(1));
            state_d    = FILL;
          end else begin
            underflow_d = 1'b1;
          end
        end
      end

      SPILL: begin
        // The freed bottom slot becomes the new top for the latched push.
        if (mem_ack_i) begin
          ring_we     = 1'b1;
          ring_waddr  = bottom_q;
          ring_wdata  = push_data_q;
          bottom_d    = bottom_q + IDX_W'(1);
          mem_count_d = mem_count_q + MC_W'(1);
          state_d     = IDLE;
        end
      end

      FILL: begin
        if (mem_ack_i) begin
          data_d      = mem_rdata_i;
          valid_d     = 1'b1;
          mem_count_d = mem_count_q - MC_W'(1);
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments only; all
  // next-state decisions were made in the combinational block above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bottom_q    <= '0;
      count_q     <= '0;
      mem_count_q <= '0;
      push_data_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      bottom_q    <= bottom_d;
      count_q     <= count_d;
      mem_count_q <= mem_count_d;
      push_data_q <= push_data_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign empty_o     = (count_q == '0) && (mem_count_q == '0);
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
  assign mem_req_o   = (state_q != IDLE);
  assign mem_we_o    = (state_q == SPILL);
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
